// File: rtl/fetch_unit_pkg.sv
// Shared widths, addressing-mode codes and fetch FSM encoding used by fetch and decode.
package fetch_unit_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int ZP_PAD     = ADDR_WIDTH - REG_WIDTH;

  // Group-01 addressing-mode field, opcode bits [4:2].
  typedef enum logic [2:0] {
    AM3_X_IND = 3'b000,
    AM3_ZPG   = 3'b001,
    AM3_IMM   = 3'b010,
    AM3_ABS   = 3'b011,
    AM3_IND_Y = 3'b100,
    AM3_ZPG_X = 3'b101,
    AM3_ABS_Y = 3'b110,
    AM3_ABS_X = 3'b111
  } am3_e;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    OPER_LO  = 3'd1,
    OPER_HI  = 3'd2,
    PTR_LO   = 3'd3,
    PTR_HI   = 3'd4,
    CALC     = 3'd5,
    READY    = 3'd6
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port and decoder handshake of the fetch stage; master = fetch_unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [REG_WIDTH-1:0]  mem_data;
  logic                  mem_valid;
  logic [REG_WIDTH-1:0]  x_in;
  logic [REG_WIDTH-1:0]  y_in;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_in;
  logic                  instruction_done;
  logic [REG_WIDTH-1:0]  instruction;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  instruction_ready;
  logic [ADDR_WIDTH-1:0] pc_out;

  modport master (
    output mem_addr, mem_rd, instruction, addr, instruction_ready, pc_out,
    input  mem_data, mem_valid, x_in, y_in, pc_load, pc_in, instruction_done
  );

  modport slave (
    input  mem_addr, mem_rd, instruction, addr, instruction_ready, pc_out,
    output mem_data, mem_valid, x_in, y_in, pc_load, pc_in, instruction_done
  );

endinterface

// File: rtl/fetch_unit_ea_calc.sv
// Combinational effective-address adder and zero-page pointer with page-0 wrap.
module fetch_unit_ea_calc
  import fetch_unit_pkg::*;
(
  input  am3_e                  mode,
  input  logic [REG_WIDTH-1:0]  op_lo,
  input  logic [REG_WIDTH-1:0]  op_hi,
  input  logic [REG_WIDTH-1:0]  ptr_lo,
  input  logic [REG_WIDTH-1:0]  ptr_hi,
  input  logic [REG_WIDTH-1:0]  x,
  input  logic [REG_WIDTH-1:0]  y,
  input  logic [ADDR_WIDTH-1:0] oper_addr,
  output logic [REG_WIDTH-1:0]  zp_ptr,
  output logic [ADDR_WIDTH-1:0] ea
);

  logic [REG_WIDTH-1:0]  zp_x;
  logic [ADDR_WIDTH-1:0] abs_base;
  logic [ADDR_WIDTH-1:0] ind_base;

  // Sums are kept at REG_WIDTH so page-zero indexing never carries into page 1.
  assign zp_x     = op_lo + x;
  assign zp_ptr   = (mode == AM3_X_IND) ? zp_x : op_lo;
  assign abs_base = {op_hi, op_lo};
  assign ind_base = {ptr_hi, ptr_lo};

  always_comb begin
    ea = '0;
    case (mode)
      AM3_X_IND: ea = ind_base;
      AM3_ZPG:   ea = {{ZP_PAD{1'b0}}, op_lo};
      AM3_IMM:   ea = oper_addr;
      AM3_ABS:   ea = abs_base;
      AM3_IND_Y: ea = ind_base + {{ZP_PAD{1'b0}}, y};
      AM3_ZPG_X: ea = {{ZP_PAD{1'b0}}, zp_x};
      AM3_ABS_Y: ea = abs_base + {{ZP_PAD{1'b0}}, y};
      AM3_ABS_X: ea = abs_base + {{ZP_PAD{1'b0}}, x};
      default:   ea = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// 6502 fetch/effective-address stage: reads opcode, operands and pointers, presents instruction+addr.
// ZPG ready 4 cycles after opcode read (ABS 5, indirect 6); every read stalls until mem_valid.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0600
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  fetch_state_e          state, state_nxt;
  logic                  rd_armed;
  logic                  xfer;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] pc, pc_inc, oper_addr, addr_q, ea;
  logic [REG_WIDTH-1:0]  instr_q, op_lo, op_hi, ptr_lo, ptr_hi;
  logic [REG_WIDTH-1:0]  zp_ptr, zp_ptr_q, zp_ptr_inc;
  am3_e                  mode;

  assign mode       = am3_e'(instr_q[4:2]);
  assign pc_inc     = pc + ADDR_WIDTH'(1);
  assign zp_ptr_inc = zp_ptr_q + REG_WIDTH'(1);
  // rd_armed holds the read port idle for the first cycle out of reset.
  assign xfer       = rd_armed && bus.mem_valid;

  fetch_unit_ea_calc u_ea_calc (
    .mode      (mode),
    .op_lo     (op_lo),
    .op_hi     (op_hi),
    .ptr_lo    (ptr_lo),
    .ptr_hi    (ptr_hi),
    .x         (bus.x_in),
    .y         (bus.y_in),
    .oper_addr (oper_addr),
    .zp_ptr    (zp_ptr),
    .ea        (ea)
  );

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    req_addr  = '0;
    case (state)
      FETCH_OP: begin
        mem_req  = rd_armed;
        req_addr = rd_armed ? pc : '0;
        if (xfer) state_nxt = OPER_LO;
      end
      OPER_LO: begin
        mem_req  = rd_armed;
        req_addr = pc;
        if (xfer) begin
          case (mode)
            AM3_IMM, AM3_ZPG, AM3_ZPG_X:  state_nxt = CALC;
            AM3_ABS, AM3_ABS_X, AM3_ABS_Y: state_nxt = OPER_HI;
            default:                       state_nxt = PTR_LO;
          endcase
        end
      end
      OPER_HI: begin
        mem_req  = rd_armed;
        req_addr = pc;
        if (xfer) state_nxt = CALC;
      end
      PTR_LO: begin
        mem_req  = rd_armed;
        req_addr = {{ZP_PAD{1'b0}}, zp_ptr};
        if (xfer) state_nxt = PTR_HI;
      end
      PTR_HI: begin
        mem_req  = rd_armed;
        req_addr = {{ZP_PAD{1'b0}}, zp_ptr_inc};
        if (xfer) state_nxt = CALC;
      end
      CALC:    state_nxt = READY;
      READY:   if (bus.instruction_done) state_nxt = FETCH_OP;
      default: state_nxt = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH_OP;
      rd_armed  <= 1'b0;
      pc        <= RESET_PC;
      instr_q   <= '0;
      op_lo     <= '0;
      op_hi     <= '0;
      ptr_lo    <= '0;
      ptr_hi    <= '0;
      zp_ptr_q  <= '0;
      oper_addr <= '0;
      addr_q    <= '0;
    end else begin
      state    <= state_nxt;
      rd_armed <= 1'b1;
      case (state)
        FETCH_OP: if (xfer) begin
          instr_q <= bus.mem_data;
          pc      <= pc_inc;
        end
        OPER_LO: if (xfer) begin
          op_lo     <= bus.mem_data;
          oper_addr <= pc;
          pc        <= pc_inc;
        end
        OPER_HI: if (xfer) begin
          op_hi <= bus.mem_data;
          pc    <= pc_inc;
        end
        PTR_LO: if (xfer) begin
          ptr_lo   <= bus.mem_data;
          zp_ptr_q <= zp_ptr;
        end
        PTR_HI:  if (xfer) ptr_hi <= bus.mem_data;
        CALC:    addr_q <= ea;
        READY:   if (bus.pc_load) pc <= bus.pc_in;
        default: ;
      endcase
    end
  end

  assign bus.mem_rd            = mem_req;
  assign bus.mem_addr          = req_addr;
  assign bus.instruction       = instr_q;
  assign bus.addr              = addr_q;
  assign bus.instruction_ready = (state == READY);
  assign bus.pc_out            = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable wait states plus an addressing-mode reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(16'h0600)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem [0:65535];
  int lat;
  int wait_cnt;

  assign bus.mem_data  = mem[bus.mem_addr];
  assign bus.mem_valid = bus.mem_rd && (wait_cnt >= lat);

  always @(posedge clk) begin
    if (!bus.mem_rd || bus.mem_valid) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  int vectors = 0;
  int errors  = 0;

  logic [15:0] exp_rd [$];
  logic [7:0]  exp_op;
  logic [15:0] exp_ea;
  logic [15:0] exp_npc;
  logic        prev_rdy = 1'b0;
  logic [15:0] chk_e;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Reference: derive read sequence, effective address and next PC straight from the mode table.
  task automatic model_instr(input logic [15:0] pc);
    logic [15:0] a1, a2, base;
    logic [7:0]  lo, zp, zp1;
    logic [2:0]  m;
    exp_op = mem[pc];
    m      = exp_op[4:2];
    exp_rd.push_back(pc);
    a1 = pc + 16'd1;
    exp_rd.push_back(a1);
    lo = mem[a1];
    exp_npc = a1 + 16'd1;
    case (m)
      3'd2: exp_ea = a1;
      3'd1: exp_ea = {8'h00, lo};
      3'd5: begin
        zp = lo + bus.x_in;
        exp_ea = {8'h00, zp};
      end
      3'd3, 3'd6, 3'd7: begin
        a2 = exp_npc;
        exp_rd.push_back(a2);
        base = {mem[a2], lo};
        exp_npc = a2 + 16'd1;
        if (m == 3'd7)      exp_ea = base + {8'h00, bus.x_in};
        else if (m == 3'd6) exp_ea = base + {8'h00, bus.y_in};
        else                exp_ea = base;
      end
      default: begin
        zp  = (m == 3'd0) ? lo + bus.x_in : lo;
        zp1 = zp + 8'd1;
        exp_rd.push_back({8'h00, zp});
        exp_rd.push_back({8'h00, zp1});
        base = {mem[{8'h00, zp1}], mem[{8'h00, zp}]};
        exp_ea = (m == 3'd4) ? base + {8'h00, bus.y_in} : base;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_valid) begin
      if (exp_rd.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rd_addr: read at %h, model expects no read", bus.mem_addr);
      end else begin
        chk_e = exp_rd.pop_front();
        check("rd_addr", bus.mem_addr, chk_e);
      end
    end
    if (bus.instruction_ready) begin
      check("instruction", {8'h00, bus.instruction}, {8'h00, exp_op});
      check("addr", bus.addr, exp_ea);
      if (!prev_rdy) check("pc_out_at_ready", bus.pc_out, exp_npc);
    end
    prev_rdy = bus.instruction_ready;
  end

  task automatic check_reset(input string nm);
    check({nm, "_mem_rd"}, {15'd0, bus.mem_rd}, 16'h0000);
    check({nm, "_mem_addr"}, bus.mem_addr, 16'h0000);
    check({nm, "_instruction"}, {8'h00, bus.instruction}, 16'h0000);
    check({nm, "_addr"}, bus.addr, 16'h0000);
    check({nm, "_ready"}, {15'd0, bus.instruction_ready}, 16'h0000);
    check({nm, "_pc_out"}, bus.pc_out, 16'h0600);
  endtask

  task automatic reset_dut(input int l);
    @(negedge clk);
    reset_n = 1'b0;
    bus.pc_load = 1'b0;
    bus.instruction_done = 1'b0;
    lat = l;
    @(negedge clk);
    @(negedge clk);
    exp_rd.delete();
    check_reset("reset");
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string nm, input int exp_lat, input logic [15:0] lit_addr,
                            input logic [15:0] lit_pc, input logic [7:0] lit_op);
    int cnt = 0;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cnt > 0) cnt++;
      else if (bus.mem_rd) cnt = 1;
      if (bus.instruction_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: instruction_ready low after 200 cycles, required high", nm);
    end else begin
      check({nm, "_op"}, {8'h00, bus.instruction}, {8'h00, lit_op});
      check({nm, "_addr"}, bus.addr, lit_addr);
      check({nm, "_pc"}, bus.pc_out, lit_pc);
      if (exp_lat > 0) check({nm, "_latency"}, 16'(cnt), 16'(exp_lat));
    end
  endtask

  // Finish the current instruction from READY and start the next one at target.
  task automatic chain(input logic [15:0] target, input bit load);
    @(negedge clk);
    #2;
    if (load) begin
      bus.pc_load = 1'b1;
      bus.pc_in   = target;
    end
    model_instr(target);
    bus.instruction_done = 1'b1;
    @(negedge clk);
    bus.pc_load = 1'b0;
    bus.instruction_done = 1'b0;
    check("fetch_addr", bus.mem_addr, target);
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] x, input logic [7:0] y);
    mem[16'h0600] = b0;
    mem[16'h0601] = b1;
    mem[16'h0602] = b2;
    bus.x_in = x;
    bus.y_in = y;
  endtask

  initial begin
    bit hit;
    reset_n = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_in = 16'h0000;
    bus.instruction_done = 1'b0;
    bus.x_in = 8'h00;
    bus.y_in = 8'h00;
    lat = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;

    load_prog(8'hA5, 8'h10, 8'hEA, 8'h00, 8'h00);
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("zpg", 4, 16'h0010, 16'h0602, 8'hA5);

    // Two pc_load cycles in READY: the later target must win.
    mem[16'h8000] = 8'hA5;
    mem[16'h8001] = 8'h77;
    @(negedge clk);
    bus.pc_load = 1'b1;
    bus.pc_in   = 16'h7000;
    @(negedge clk);
    bus.pc_in   = 16'h8000;
    @(negedge clk);
    bus.pc_load = 1'b0;
    check("pc_load_last_wins", bus.pc_out, 16'h8000);
    chain(16'h8000, 1'b0);
    wait_ready("redirect", -1, 16'h0077, 16'h8002, 8'hA5);

    mem[16'hFFFF] = 8'hA5;
    mem[16'h0000] = 8'h33;
    chain(16'hFFFF, 1'b1);
    wait_ready("pc_wrap", -1, 16'h0033, 16'h0001, 8'hA5);

    load_prog(8'hBD, 8'hFF, 8'h12, 8'h01, 8'h00);
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("abs_x", 5, 16'h1300, 16'h0603, 8'hBD);

    load_prog(8'hB5, 8'hF0, 8'hEA, 8'h20, 8'h00);
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("zpg_x", 4, 16'h0010, 16'h0602, 8'hB5);

    load_prog(8'hA1, 8'hFE, 8'hEA, 8'h01, 8'h00);
    mem[16'h00FF] = 8'h34;
    mem[16'h0000] = 8'h12;
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("x_ind", 6, 16'h1234, 16'h0602, 8'hA1);

    load_prog(8'hB1, 8'h40, 8'hEA, 8'h00, 8'h02);
    mem[16'h0040] = 8'hFF;
    mem[16'h0041] = 8'hFF;
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("ind_y", 6, 16'h0001, 16'h0602, 8'hB1);

    load_prog(8'hA9, 8'h5A, 8'hEA, 8'h00, 8'h00);
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("imm", 4, 16'h0601, 16'h0602, 8'hA9);

    // pc_load and instruction_done asserted before READY must be ignored.
    load_prog(8'hAD, 8'h34, 8'h12, 8'h00, 8'h00);
    reset_dut(0);
    model_instr(16'h0600);
    bus.pc_load = 1'b1;
    bus.pc_in   = 16'h4444;
    bus.instruction_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.pc_load = 1'b0;
    bus.instruction_done = 1'b0;
    wait_ready("abs", -1, 16'h1234, 16'h0603, 8'hAD);

    load_prog(8'hB9, 8'hF0, 8'h12, 8'h00, 8'h20);
    reset_dut(0);
    model_instr(16'h0600);
    wait_ready("abs_y", 5, 16'h1310, 16'h0603, 8'hB9);

    load_prog(8'hA5, 8'h10, 8'hEA, 8'h00, 8'h00);
    reset_dut(3);
    model_instr(16'h0600);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_rd) begin
        hit = 1;
        break;
      end
    end
    check("stall_rd_seen", {15'd0, hit}, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_mem_rd", {15'd0, bus.mem_rd}, 16'h0001);
      check("stall_mem_addr", bus.mem_addr, 16'h0600);
      check("stall_pc", bus.pc_out, 16'h0600);
    end
    wait_ready("stall", -1, 16'h0010, 16'h0602, 8'hA5);

    // Reset during the PTR_HI read, with mem_valid high in that same cycle.
    load_prog(8'hA1, 8'hFE, 8'hEA, 8'h01, 8'h00);
    mem[16'h00FF] = 8'h34;
    mem[16'h0000] = 8'h12;
    reset_dut(0);
    model_instr(16'h0600);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr == 16'h0000) begin
        hit = 1;
        break;
      end
    end
    check("ptr_hi_reached", {15'd0, hit}, 16'h0001);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    exp_rd.delete();
    reset_n = 1'b1;
    model_instr(16'h0600);
    wait_ready("after_reset", 6, 16'h1234, 16'h0602, 8'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
